// File: rtl/mc_control_fsm_if.sv
// Control-sequencer bundle: instruction fields and handshake inputs, datapath control outputs.
// master = sequencer side, slave = datapath/memory side.
interface mc_control_fsm_if;
  logic       run_i;
  logic [2:0] opcode_i;
  logic [2:0] funct_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       mem_rd_o;
  logic       mem_wr_o;
  logic       iord_o;
  logic       ir_we_o;
  logic       pc_we_o;
  logic [1:0] pc_src_o;
  logic       reg_we_o;
  logic [1:0] reg_dst_o;
  logic [1:0] wb_sel_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_control_o;
  logic       instr_done_o;
  logic       err_o;

  modport master (
    input  run_i, opcode_i, funct_i, zero_i, mem_ready_i,
    output mem_rd_o, mem_wr_o, iord_o, ir_we_o, pc_we_o, pc_src_o, reg_we_o,
           reg_dst_o, wb_sel_o, alu_src_a_o, alu_src_b_o, alu_control_o,
           instr_done_o, err_o
  );

  modport slave (
    output run_i, opcode_i, funct_i, zero_i, mem_ready_i,
    input  mem_rd_o, mem_wr_o, iord_o, ir_we_o, pc_we_o, pc_src_o, reg_we_o,
           reg_dst_o, wb_sel_o, alu_src_a_o, alu_src_b_o, alu_control_o,
           instr_done_o, err_o
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit MIPS datapath.
// Moore outputs per state; FETCH/BRANCH/MEM_WR enables are qualified by mem_ready/zero.
module mc_control_fsm #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  mc_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_ERR
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_SLTI = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b111;
  localparam logic [2:0] FN_SLT  = 3'b100;
  localparam logic [2:0] FN_JR   = 3'b101;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_wait;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    mem_wait          = 1'b0;
    bus.mem_rd_o      = 1'b0;
    bus.mem_wr_o      = 1'b0;
    bus.iord_o        = 1'b0;
    bus.ir_we_o       = 1'b0;
    bus.pc_we_o       = 1'b0;
    bus.pc_src_o      = 2'b00;
    bus.reg_we_o      = 1'b0;
    bus.reg_dst_o     = 2'b00;
    bus.wb_sel_o      = 2'b00;
    bus.alu_src_a_o   = 1'b0;
    bus.alu_src_b_o   = 2'b00;
    bus.alu_control_o = 3'b000;
    bus.instr_done_o  = 1'b0;
    bus.err_o         = 1'b0;

    case (state_q)
      S_IDLE: if (bus.run_i) state_d = S_FETCH;
      S_FETCH: begin
        mem_wait         = 1'b1;
        bus.mem_rd_o     = 1'b1;
        bus.alu_src_b_o  = 2'b01;
        bus.ir_we_o      = bus.mem_ready_i;
        bus.pc_we_o      = bus.mem_ready_i;
        if (bus.mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        // PC + (imm<<1) lands in alu_out for a possible branch
        bus.alu_src_b_o = 2'b11;
        case (bus.opcode_i)
          OP_R: begin
            if (bus.funct_i == FN_JR)      state_d = S_JR;
            else if (bus.funct_i > FN_JR)  state_d = S_ERR;
            else                           state_d = S_EXEC_R;
          end
          OP_SLTI, OP_ADDI: state_d = S_EXEC_I;
          OP_J, OP_JAL:     state_d = S_JUMP;
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          default:          state_d = S_BRANCH;
        endcase
      end
      S_EXEC_R: begin
        bus.alu_src_a_o   = 1'b1;
        bus.alu_control_o = bus.funct_i;
        state_d           = S_WB_R;
      end
      S_WB_R: begin
        bus.reg_we_o     = 1'b1;
        bus.reg_dst_o    = 2'b01;
        bus.instr_done_o = 1'b1;
        state_d          = S_FETCH;
      end
      S_EXEC_I: begin
        bus.alu_src_a_o   = 1'b1;
        bus.alu_src_b_o   = 2'b10;
        bus.alu_control_o = (bus.opcode_i == OP_SLTI) ? FN_SLT : 3'b000;
        state_d           = S_WB_I;
      end
      S_WB_I: begin
        bus.reg_we_o     = 1'b1;
        bus.instr_done_o = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'b10;
        state_d         = (bus.opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_wait     = 1'b1;
        bus.mem_rd_o = 1'b1;
        bus.iord_o   = 1'b1;
        if (bus.mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.reg_we_o     = 1'b1;
        bus.wb_sel_o     = 2'b01;
        bus.instr_done_o = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEM_WR: begin
        mem_wait         = 1'b1;
        bus.mem_wr_o     = 1'b1;
        bus.iord_o       = 1'b1;
        bus.instr_done_o = bus.mem_ready_i;
        if (bus.mem_ready_i) state_d = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a_o   = 1'b1;
        bus.alu_control_o = 3'b001;
        bus.pc_src_o      = 2'b01;
        bus.pc_we_o       = bus.zero_i;
        bus.instr_done_o  = 1'b1;
        state_d           = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_we_o      = 1'b1;
        bus.pc_src_o     = 2'b10;
        bus.instr_done_o = 1'b1;
        if (bus.opcode_i == OP_JAL) begin
          bus.reg_we_o  = 1'b1;
          bus.reg_dst_o = 2'b10;
          bus.wb_sel_o  = 2'b10;
        end
        state_d = S_FETCH;
      end
      S_JR: begin
        bus.pc_we_o      = 1'b1;
        bus.pc_src_o     = 2'b11;
        bus.instr_done_o = 1'b1;
        state_d          = S_FETCH;
      end
      S_ERR:   bus.err_o = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // a ready arriving on the limit cycle still completes the access
    if (mem_wait && !bus.mem_ready_i && (wait_cnt_q == CNT_W'(WAIT_LIMIT)))
      state_d = S_ERR;

    wait_cnt_d = (mem_wait && !bus.mem_ready_i && (state_d == state_q))
                 ? wait_cnt_q + CNT_W'(1) : '0;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: latency/last-cycle table, randomized instruction stream
// checked cycle by cycle against an instruction-level model, and reset/timeout/error corners.
module tb_mc_control_fsm;

  localparam int WAIT_LIMIT = 16;

  logic clk;
  logic reset;
  mc_control_fsm_if bus ();

  mc_control_fsm #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  fn;
    logic        z;
    int          len;
    logic [19:0] last;
  } vec_t;

  typedef struct {
    logic        rdy;
    logic        z;
    logic [19:0] w;
  } cyc_t;

  vec_t tbl[12];
  cyc_t q[$];

  // control word: {rd,wr,iord,ir_we,pc_we,pc_src,reg_we,reg_dst,wb_sel,src_a,src_b,alu,done,err}
  function automatic logic [19:0] cw(input logic rd, input logic wr, input logic iord,
                                     input logic irwe, input logic pcwe, input logic [1:0] pcs,
                                     input logic rwe, input logic [1:0] rdst, input logic [1:0] wbs,
                                     input logic a, input logic [1:0] b, input logic [2:0] alu,
                                     input logic dn, input logic er);
    return {rd, wr, iord, irwe, pcwe, pcs, rwe, rdst, wbs, a, b, alu, dn, er};
  endfunction

  function automatic logic [19:0] get_w();
    return {bus.mem_rd_o, bus.mem_wr_o, bus.iord_o, bus.ir_we_o, bus.pc_we_o, bus.pc_src_o,
            bus.reg_we_o, bus.reg_dst_o, bus.wb_sel_o, bus.alu_src_a_o, bus.alu_src_b_o,
            bus.alu_control_o, bus.instr_done_o, bus.err_o};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic r, input logic z, input logic [19:0] w);
    cyc_t c;
    c.rdy = r; c.z = z; c.w = w;
    q.push_back(c);
  endfunction

  // Instruction-level model: expected control word per cycle for one instruction,
  // df/dm = cycles mem_ready stays low in the fetch / data access.
  function automatic void build(input logic [2:0] op, input logic [2:0] fn, input logic z,
                                input int df, input int dm);
    logic [19:0] err_w;
    err_w = cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,3'b000,0,1);
    q.delete();
    for (int i = 0; i < df; i++)
      push(1'b0, rb(), cw(1,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b01,3'b000,0,0));
    push(1'b1, rb(), cw(1,0,0,1,1,2'b00,0,2'b00,2'b00,0,2'b01,3'b000,0,0));
    push(rb(), rb(), cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b11,3'b000,0,0));
    case (op)
      3'd0: begin
        if (fn == 3'd5) push(rb(), rb(), cw(0,0,0,0,1,2'b11,0,2'b00,2'b00,0,2'b00,3'b000,1,0));
        else if (fn > 3'd5) push(rb(), rb(), err_w);
        else begin
          push(rb(), rb(), cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,fn,0,0));
          push(rb(), rb(), cw(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,3'b000,1,0));
        end
      end
      3'd1, 3'd7: begin
        push(rb(), rb(), cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b10,(op == 3'd1) ? 3'b100 : 3'b000,0,0));
        push(rb(), rb(), cw(0,0,0,0,0,2'b00,1,2'b00,2'b00,0,2'b00,3'b000,1,0));
      end
      3'd2: push(rb(), rb(), cw(0,0,0,0,1,2'b10,0,2'b00,2'b00,0,2'b00,3'b000,1,0));
      3'd3: push(rb(), rb(), cw(0,0,0,0,1,2'b10,1,2'b10,2'b10,0,2'b00,3'b000,1,0));
      3'd4: begin
        push(rb(), rb(), cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b10,3'b000,0,0));
        for (int i = 0; i <= dm; i++)
          push(i == dm, rb(), cw(1,0,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,3'b000,0,0));
        push(rb(), rb(), cw(0,0,0,0,0,2'b00,1,2'b00,2'b01,0,2'b00,3'b000,1,0));
      end
      3'd5: begin
        push(rb(), rb(), cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b10,3'b000,0,0));
        for (int i = 0; i <= dm; i++)
          push(i == dm, rb(), cw(0,1,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,3'b000,i == dm,0));
      end
      default: push(rb(), z, cw(0,0,0,0,z,2'b01,0,2'b00,2'b00,1,2'b00,3'b001,1,0));
    endcase
  endfunction

  task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%05h expected=%05h t=%0t", name, got, exp, $time);
    end
  endtask

  // drive one cycle, compare outputs at negedge, return at posedge+1
  task automatic step_chk(input logic r, input logic z, input logic [19:0] exp, input string name);
    bus.mem_ready_i = r;
    bus.zero_i      = z;
    @(negedge clk);
    chk(name, get_w(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic run_q(input string name);
    for (int i = 0; i < q.size(); i++)
      step_chk(q[i].rdy, q[i].z, q[i].w, name);
  endtask

  task automatic do_reset(input string name);
    bus.run_i = 1'b0;
    reset = 1'b1;
    #1;
    chk(name, get_w(), 20'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step_chk(rb(), rb(), 20'h0, "idle_norun");
  endtask

  task automatic start_run();
    bus.run_i = 1'b1;
    step_chk(rb(), rb(), 20'h0, "idle_run");
    bus.run_i = 1'b0;
  endtask

  initial begin
    int          n;
    logic        seen;
    logic [19:0] got;
    logic [2:0]  op, fn;

    tbl[0]  = '{3'd0, 3'd0, 1'b0, 4, cw(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,3'b000,1,0)};
    tbl[1]  = '{3'd0, 3'd1, 1'b1, 4, cw(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,3'b000,1,0)};
    tbl[2]  = '{3'd0, 3'd4, 1'b0, 4, cw(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,3'b000,1,0)};
    tbl[3]  = '{3'd0, 3'd5, 1'b0, 3, cw(0,0,0,0,1,2'b11,0,2'b00,2'b00,0,2'b00,3'b000,1,0)};
    tbl[4]  = '{3'd1, 3'd0, 1'b0, 4, cw(0,0,0,0,0,2'b00,1,2'b00,2'b00,0,2'b00,3'b000,1,0)};
    tbl[5]  = '{3'd2, 3'd0, 1'b0, 3, cw(0,0,0,0,1,2'b10,0,2'b00,2'b00,0,2'b00,3'b000,1,0)};
    tbl[6]  = '{3'd3, 3'd0, 1'b0, 3, cw(0,0,0,0,1,2'b10,1,2'b10,2'b10,0,2'b00,3'b000,1,0)};
    tbl[7]  = '{3'd4, 3'd0, 1'b0, 5, cw(0,0,0,0,0,2'b00,1,2'b00,2'b01,0,2'b00,3'b000,1,0)};
    tbl[8]  = '{3'd5, 3'd0, 1'b0, 4, cw(0,1,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,3'b000,1,0)};
    tbl[9]  = '{3'd6, 3'd0, 1'b1, 3, cw(0,0,0,0,1,2'b01,0,2'b00,2'b00,1,2'b00,3'b001,1,0)};
    tbl[10] = '{3'd6, 3'd0, 1'b0, 3, cw(0,0,0,0,0,2'b01,0,2'b00,2'b00,1,2'b00,3'b001,1,0)};
    tbl[11] = '{3'd7, 3'd0, 1'b0, 4, cw(0,0,0,0,0,2'b00,1,2'b00,2'b00,0,2'b00,3'b000,1,0)};

    reset = 1'b1;
    bus.run_i = 1'b0;
    bus.opcode_i = 3'd0;
    bus.funct_i = 3'd0;
    bus.zero_i = 1'b0;
    bus.mem_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_idle", get_w(), 20'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step_chk(1'b1, 1'b0, 20'h0, "idle_norun");
    start_run();

    // zero-wait latency and final-cycle controls
    for (int i = 0; i < 12; i++) begin
      bus.opcode_i = tbl[i].op;
      bus.funct_i = tbl[i].fn;
      bus.zero_i = tbl[i].z;
      bus.mem_ready_i = 1'b1;
      n = 0; seen = 1'b0; got = '0;
      while (!seen && n < 20) begin
        @(negedge clk);
        n++;
        if (bus.instr_done_o) begin
          seen = 1'b1;
          got = get_w();
        end
        @(posedge clk);
        #1;
      end
      chk($sformatf("tbl%0d_len", i), 20'(n), 20'(tbl[i].len));
      chk($sformatf("tbl%0d_last", i), got, tbl[i].last);
    end

    // random instruction stream with random memory wait states
    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(0, 7));
      fn = (op == 3'd0) ? 3'($urandom_range(0, 5)) : 3'($urandom);
      bus.opcode_i = op;
      bus.funct_i = fn;
      build(op, fn, rb(), $urandom_range(0, 4), $urandom_range(0, 4));
      run_q($sformatf("rand%0d_op%0d", k, op));
    end

    bus.opcode_i = 3'd4; bus.funct_i = 3'd0;
    build(3'd4, 3'd0, 1'b0, 0, 3);
    run_q("lw_wait3");

    bus.opcode_i = 3'd2;
    build(3'd2, 3'd0, 1'b0, WAIT_LIMIT, 0);
    run_q("fetch_ready_at_limit");

    q.delete();
    for (int i = 0; i <= WAIT_LIMIT; i++)
      push(1'b0, rb(), cw(1,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b01,3'b000,0,0));
    repeat (3) push(1'b1, rb(), cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,3'b000,0,1));
    run_q("fetch_timeout");
    do_reset("rst_from_timeout");
    start_run();

    bus.opcode_i = 3'd0; bus.funct_i = 3'd7;
    build(3'd0, 3'd7, 1'b0, 0, 0);
    repeat (3) push(rb(), rb(), cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,3'b000,0,1));
    bus.run_i = 1'b1;
    run_q("r_funct7_err");
    do_reset("rst_from_err");
    start_run();

    // sw stalled in MEM_WR, then reset lands mid-cycle
    bus.opcode_i = 3'd5; bus.funct_i = 3'd0;
    build(3'd5, 3'd0, 1'b0, 0, 6);
    for (int i = 0; i < 5; i++)
      step_chk(q[i].rdy, q[i].z, q[i].w, "sw_stall");
    #1;
    chk("memwr_before_rst", 20'(bus.mem_wr_o), 20'd1);
    bus.mem_ready_i = 1'b1;
    reset = 1'b1;
    #1;
    chk("memwr_async_drop", get_w(), 20'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step_chk(1'b1, 1'b0, 20'h0, "post_rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
